// File: rtl/lmc_sequencer_pkg.sv
// Shared types and instruction-field constants for the LMC sequencer.
package lmc_sequencer_pkg;

  // Debug encoding of the sequencer state is exported on the state port.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  // Instruction word bit positions.
  localparam int IR_RAM2_WE = 11;
  localparam int IR_ACC_WE  = 10;
  localparam int IR_OUT_WE  = 9;
  localparam int IR_MUX_HI  = 8;
  localparam int IR_MUX_LO  = 7;
  localparam int IR_JMP     = 6;
  localparam int IR_JZ      = 5;
  localparam int IR_JP      = 4;
  localparam int IR_TGT_HI  = 3;
  localparam int IR_TGT_LO  = 0;
  localparam int IR_RA_HI   = 2;
  localparam int IR_RA_LO   = 0;

  // Accumulator source select codes.
  localparam logic [1:0] MUX_DATA_IN = 2'b00;
  localparam logic [1:0] MUX_SUM     = 2'b01;
  localparam logic [1:0] MUX_SUB     = 2'b10;
  localparam logic [1:0] MUX_RAM2    = 2'b11;

  // Datapath controls decoded from one instruction.
  typedef struct packed {
    logic       ram2_we;
    logic       acc_we;
    logic       out_we;
    logic [1:0] mux_sel;
    logic [2:0] ram2_addr;
  } exec_ctrl_t;

endpackage

// File: rtl/lmc_branch_unit.sv
// Next-PC selection: taken jump loads the target field, otherwise pc+1.
module lmc_branch_unit
  import lmc_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic [IR_JMP:0]      ir,
  input  logic                 z_flag,
  input  logic                 pz_flag,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  logic take;

  assign take    = ir[IR_JMP] | (ir[IR_JZ] & z_flag) | (ir[IR_JP] & pz_flag);
  assign next_pc = take ? ADDR_WIDTH'(ir[IR_TGT_HI:IR_TGT_LO]) : pc + ADDR_WIDTH'(1);

endmodule

// File: rtl/lmc_sequencer.sv
// LMC control sequencer: program load, fetch/exec/writeback, halt, single step.
module lmc_sequencer
  import lmc_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  timer555,
  input  logic                  reset_count,
  input  logic                  run,
  input  logic                  step_req,
  output logic                  step_ack,
  input  logic                  load_mode,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] prog_wdata,
  output logic                  prog_we,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  z_flag,
  input  logic                  pz_flag,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  acc_we,
  output logic                  ram2_we,
  output logic                  out_we,
  output logic [1:0]            mux_sel,
  output logic [2:0]            ram2_addr,
  output logic                  halted,
  output logic [2:0]            state
);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] ir;
  logic                  step_armed;
  logic                  step_active;
  logic                  ir_halt;
  logic [ADDR_WIDTH-1:0] next_pc;
  exec_ctrl_t            fetch_ctrl;

  // Controls are decoded from the incoming word so they are valid on EXEC entry.
  assign fetch_ctrl = '{
    ram2_we:   instr[IR_RAM2_WE],
    acc_we:    instr[IR_ACC_WE],
    out_we:    instr[IR_OUT_WE],
    mux_sel:   instr[IR_MUX_HI:IR_MUX_LO],
    ram2_addr: instr[IR_RA_HI:IR_RA_LO]
  };

  assign ir_halt    = (ir[IR_RAM2_WE:IR_JP] == '0);
  assign prog_we    = (state_q == S_LOAD) && load_valid;
  assign prog_wdata = load_data;
  assign load_ready = (state_q == S_LOAD);
  assign halted     = (state_q == S_HALT);
  assign state      = state_q;

  lmc_branch_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_branch (
    .ir      (ir[IR_JMP:0]),
    .z_flag  (z_flag),
    .pz_flag (pz_flag),
    .pc      (pc),
    .next_pc (next_pc)
  );

  // Sequencer FSM with registered strobes, pc and step handshake.
  always_ff @(posedge timer555 or negedge reset_count) begin
    if (!reset_count) begin
      state_q     <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      step_armed  <= 1'b1;
      step_active <= 1'b0;
      step_ack    <= 1'b0;
      acc_we      <= 1'b0;
      ram2_we     <= 1'b0;
      out_we      <= 1'b0;
      mux_sel     <= MUX_DATA_IN;
      ram2_addr   <= '0;
    end else begin
      // Strobes are one-cycle pulses; only the FETCH->EXEC edge sets them.
      acc_we  <= 1'b0;
      ram2_we <= 1'b0;
      out_we  <= 1'b0;
      // Dropping step_req both releases the ack and re-arms the next step.
      if (!step_req) begin
        step_armed <= 1'b1;
        step_ack   <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (load_mode) begin
            state_q <= S_LOAD;
            pc      <= '0;
          end else if (run) begin
            state_q <= S_FETCH;
          end else if (step_req && step_armed) begin
            state_q     <= S_FETCH;
            step_armed  <= 1'b0;
            step_active <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!load_mode) begin
            state_q <= S_IDLE;
            pc      <= '0;
          end else if (load_valid) begin
            pc <= pc + ADDR_WIDTH'(1);
          end
        end
        S_FETCH: begin
          ir        <= instr;
          acc_we    <= fetch_ctrl.acc_we;
          ram2_we   <= fetch_ctrl.ram2_we;
          out_we    <= fetch_ctrl.out_we;
          mux_sel   <= fetch_ctrl.mux_sel;
          ram2_addr <= fetch_ctrl.ram2_addr;
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          if (ir_halt) begin
            state_q     <= S_HALT;
            step_active <= 1'b0;
          end else begin
            state_q <= S_WB;
            if (step_active && step_req) step_ack <= 1'b1;
          end
        end
        S_WB: begin
          pc          <= next_pc;
          step_active <= 1'b0;
          state_q     <= run ? S_FETCH : S_IDLE;
        end
        S_HALT: begin
          if (load_mode) begin
            state_q <= S_LOAD;
            pc      <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lmc_sequencer.sv
// Directed self-checking bench for lmc_sequencer.
module tb_lmc_sequencer;

  logic        timer555 = 1'b0;
  logic        reset_count;
  logic        run, step_req, step_ack;
  logic        load_mode, load_valid, load_ready;
  logic [11:0] load_data, prog_wdata, instr;
  logic        prog_we, z_flag, pz_flag;
  logic [3:0]  pc;
  logic        acc_we, ram2_we, out_we, halted;
  logic [1:0]  mux_sel;
  logic [2:0]  ram2_addr, state;

  int errors = 0;
  int checks = 0;

  logic [11:0] pmem [16];
  assign instr = pmem[pc];

  always #5 timer555 = ~timer555;

  lmc_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(12)) dut (
    .timer555(timer555), .reset_count(reset_count), .run(run),
    .step_req(step_req), .step_ack(step_ack), .load_mode(load_mode),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .prog_wdata(prog_wdata), .prog_we(prog_we), .instr(instr),
    .z_flag(z_flag), .pz_flag(pz_flag), .pc(pc), .acc_we(acc_we),
    .ram2_we(ram2_we), .out_we(out_we), .mux_sel(mux_sel),
    .ram2_addr(ram2_addr), .halted(halted), .state(state)
  );

  task automatic tick();
    @(posedge timer555);
    #1;
  endtask

  // One instruction via a one-cycle run pulse, ending back in IDLE.
  task automatic run_one();
    run = 1'b1; tick(); run = 1'b0; tick(); tick(); tick();
  endtask

  task automatic test_reset();
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
    checks++; if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc got=%0d want=0", pc); end
    checks++; if ({acc_we, ram2_we, out_we, step_ack, load_ready, halted, prog_we} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes got=%b want=0000000", {acc_we, ram2_we, out_we, step_ack, load_ready, halted, prog_we}); end
    checks++; if ({mux_sel, ram2_addr} !== 5'b0) begin errors++; $display("FAIL reset_mux_addr got=%b want=00000", {mux_sel, ram2_addr}); end
    reset_count = 1'b1;
  endtask

  task automatic test_load();
    load_mode = 1'b1; tick();
    checks++; if (state !== 3'd1 || load_ready !== 1'b1) begin errors++; $display("FAIL load_entry state=%0d ready=%b want 1/1", state, load_ready); end
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = 12'h100 + 12'(i); #1;
      checks++; if (prog_we !== 1'b1 || pc !== 4'(i) || prog_wdata !== 12'h100 + 12'(i)) begin
        errors++; $display("FAIL load_word%0d we=%b pc=%0d wdata=%h want 1/%0d/%h", i, prog_we, pc, prog_wdata, i, 12'h100 + 12'(i)); end
      tick();
    end
    load_valid = 1'b0; #1;
    checks++; if (prog_we !== 1'b0 || pc !== 4'd3) begin errors++; $display("FAIL load_after3 we=%b pc=%0d want 0/3", prog_we, pc); end
    load_valid = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    load_valid = 1'b0; #1;
    checks++; if (pc !== 4'd0 || state !== 3'd1) begin errors++; $display("FAIL load_wrap pc=%0d state=%0d want 0/1", pc, state); end
    load_valid = 1'b1; load_data = 12'h0AB; tick(); load_valid = 1'b0;
    load_mode = 1'b0; tick();
    checks++; if (state !== 3'd0 || pc !== 4'd0 || load_ready !== 1'b0) begin
      errors++; $display("FAIL load_exit state=%0d pc=%0d ready=%b want 0/0/0", state, pc, load_ready); end
  endtask

  task automatic test_run_acc();
    pmem[0] = 12'h400;
    run = 1'b1; tick();
    checks++; if (state !== 3'd2 || acc_we !== 1'b0) begin errors++; $display("FAIL acc_fetch state=%0d acc_we=%b want 2/0", state, acc_we); end
    tick();
    checks++; if (state !== 3'd3 || {acc_we, ram2_we, out_we} !== 3'b100 || mux_sel !== 2'b00) begin
      errors++; $display("FAIL acc_exec state=%0d strobes=%b mux=%b want 3/100/00", state, {acc_we, ram2_we, out_we}, mux_sel); end
    run = 1'b0; tick();
    checks++; if (state !== 3'd4 || acc_we !== 1'b0 || pc !== 4'd0) begin
      errors++; $display("FAIL acc_wb state=%0d acc_we=%b pc=%0d want 4/0/0", state, acc_we, pc); end
    tick();
    checks++; if (state !== 3'd0 || pc !== 4'd1) begin errors++; $display("FAIL acc_done state=%0d pc=%0d want 0/1", state, pc); end
  endtask

  task automatic test_exec_fields();
    pmem[1] = 12'hA85;
    run = 1'b1; tick(); run = 1'b0; tick();
    checks++; if ({ram2_we, acc_we, out_we} !== 3'b101 || mux_sel !== 2'b01 || ram2_addr !== 3'd5) begin
      errors++; $display("FAIL fields_exec strobes=%b mux=%b addr=%0d want 101/01/5", {ram2_we, acc_we, out_we}, mux_sel, ram2_addr); end
    tick();
    checks++; if ({ram2_we, acc_we, out_we} !== 3'b000 || mux_sel !== 2'b01 || ram2_addr !== 3'd5) begin
      errors++; $display("FAIL fields_wb strobes=%b mux=%b addr=%0d want 000/01/5", {ram2_we, acc_we, out_we}, mux_sel, ram2_addr); end
    tick();
    checks++; if (pc !== 4'd2) begin errors++; $display("FAIL fields_pc got=%0d want=2", pc); end
  endtask

  task automatic test_branch();
    pmem[2] = 12'h04A; run_one();
    checks++; if (pc !== 4'hA) begin errors++; $display("FAIL br_jmp pc=%0d want=10", pc); end
    pmem[10] = 12'h025; z_flag = 1'b1; run_one();
    checks++; if (pc !== 4'd5) begin errors++; $display("FAIL br_jz_taken pc=%0d want=5", pc); end
    pmem[5] = 12'h025; z_flag = 1'b0; run_one();
    checks++; if (pc !== 4'd6) begin errors++; $display("FAIL br_jz_not pc=%0d want=6", pc); end
    pmem[6] = 12'h018; pz_flag = 1'b1; run_one();
    checks++; if (pc !== 4'd8) begin errors++; $display("FAIL br_jp_taken pc=%0d want=8", pc); end
    pmem[8] = 12'h013; pz_flag = 1'b0; z_flag = 1'b1; run_one();
    checks++; if (pc !== 4'd9) begin errors++; $display("FAIL br_jp_not pc=%0d want=9", pc); end
    z_flag = 1'b0;
  endtask

  task automatic test_wrap_halt();
    pmem[9] = 12'h04F; run_one();
    checks++; if (pc !== 4'hF) begin errors++; $display("FAIL wrap_setup pc=%0d want=15", pc); end
    pmem[15] = 12'h200; run_one();
    checks++; if (pc !== 4'd0) begin errors++; $display("FAIL wrap_pc pc=%0d want=0", pc); end
    pmem[0] = 12'h000;
    run = 1'b1; tick(); tick();
    checks++; if (state !== 3'd3 || {acc_we, ram2_we, out_we} !== 3'b000) begin
      errors++; $display("FAIL halt_exec state=%0d strobes=%b want 3/000", state, {acc_we, ram2_we, out_we}); end
    tick();
    checks++; if (state !== 3'd5 || halted !== 1'b1) begin errors++; $display("FAIL halt_enter state=%0d halted=%b want 5/1", state, halted); end
    tick(); tick(); tick();
    checks++; if (state !== 3'd5 || halted !== 1'b1 || pc !== 4'd0 || acc_we !== 1'b0) begin
      errors++; $display("FAIL halt_hold state=%0d halted=%b pc=%0d want 5/1/0", state, halted, pc); end
    run = 1'b0; load_mode = 1'b1; tick();
    checks++; if (state !== 3'd1 || halted !== 1'b0) begin errors++; $display("FAIL halt_to_load state=%0d halted=%b want 1/0", state, halted); end
    load_mode = 1'b0; tick();
  endtask

  task automatic test_step();
    int acc_pulses;
    acc_pulses = 0;
    pmem[0] = 12'h400; pmem[1] = 12'h400;
    step_req = 1'b1;
    tick(); if (acc_we) acc_pulses++;
    tick(); if (acc_we) acc_pulses++;
    tick(); if (acc_we) acc_pulses++;
    checks++; if (state !== 3'd4 || step_ack !== 1'b1) begin errors++; $display("FAIL step_wb state=%0d ack=%b want 4/1", state, step_ack); end
    for (int i = 0; i < 5; i++) begin tick(); if (acc_we) acc_pulses++; end
    checks++; if (state !== 3'd0 || pc !== 4'd1 || step_ack !== 1'b1) begin
      errors++; $display("FAIL step_hold state=%0d pc=%0d ack=%b want 0/1/1", state, pc, step_ack); end
    checks++; if (acc_pulses !== 1) begin errors++; $display("FAIL step_once pulses=%0d want=1", acc_pulses); end
    step_req = 1'b0; tick();
    checks++; if (step_ack !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL step_release ack=%b state=%0d want 0/0", step_ack, state); end
    step_req = 1'b1; tick();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL step_rearm state=%0d want=2", state); end
    tick(); tick(); tick();
    checks++; if (pc !== 4'd2 || state !== 3'd0) begin errors++; $display("FAIL step_second pc=%0d state=%0d want 2/0", pc, state); end
    step_req = 1'b0; tick();
  endtask

  task automatic test_reset_exec();
    pmem[2] = 12'hE00;
    run = 1'b1; tick(); tick();
    checks++; if ({ram2_we, acc_we, out_we} !== 3'b111) begin errors++; $display("FAIL rst_exec_pre strobes=%b want=111", {ram2_we, acc_we, out_we}); end
    reset_count = 1'b0; #1;
    checks++; if ({ram2_we, acc_we, out_we} !== 3'b000 || state !== 3'd0 || pc !== 4'd0) begin
      errors++; $display("FAIL rst_exec_async strobes=%b state=%0d pc=%0d want 000/0/0", {ram2_we, acc_we, out_we}, state, pc); end
    #3; reset_count = 1'b1; tick();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL rst_release state=%0d want=2", state); end
    run = 1'b0; tick(); tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pmem[i] = 12'h000;
    reset_count = 1'b0; run = 1'b0; step_req = 1'b0;
    load_mode = 1'b0; load_valid = 1'b0; load_data = '0;
    z_flag = 1'b0; pz_flag = 1'b0;
    test_reset();
    test_load();
    test_run_acc();
    test_exec_fields();
    test_branch();
    test_wrap_halt();
    test_step();
    test_reset_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lmc_sequencer.md
LMC_SEQUENCER -- requirements
Module: lmc_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH SHALL default to 4 and set the program-counter and program-address width.
REQ-002 Parameter DATA_WIDTH SHALL default to 12 and set the instruction and load-data width.
REQ-003 timer555  in  1  single clock; all state SHALL change on the rising edge only.
REQ-004 reset_count  in  1  asynchronous, active-low reset.
REQ-005 run  in  1  level; free-run enable.
REQ-006 step_req / step_ack  in/out  1/1  four-phase single-step handshake.
REQ-007 load_mode  in  1  level; program-load mode request.
REQ-008 load_valid / load_ready  in/out  1/1  load-word handshake.
REQ-009 load_data  in  DATA_WIDTH  word to write; prog_wdata  out  DATA_WIDTH  equals load_data.
REQ-010 prog_we  out  1  program-memory write strobe.
REQ-011 instr  in  DATA_WIDTH  program-memory read data at address pc.
REQ-012 z_flag, pz_flag  in  1 each  accumulator zero and non-negative flags.
REQ-013 pc  out  ADDR_WIDTH  program address.
REQ-014 acc_we, ram2_we, out_we  out  1 each  one-cycle datapath strobes.
REQ-015 mux_sel  out  2  accumulator source select: 00 data_in, 01 sum, 10 subtract, 11 RAM2.
REQ-016 ram2_addr  out  3  data-memory address; halted  out  1; state  out  3  debug encoding.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, FETCH, EXEC, WB, HALT.
REQ-018 In IDLE the priority SHALL be: load_mode -> LOAD; else run -> FETCH; else step_req with the step armed -> FETCH.
REQ-019 LOAD behaviour:
- pc SHALL be cleared to 0 on entry.
- load_ready SHALL be 1 while in LOAD.
- On each cycle with load_valid=1: prog_we=1 that cycle and pc increments.
- After the write to address 15, pc SHALL wrap to 0 and the FSM SHALL stay in LOAD.
- load_mode=0 SHALL return the FSM to IDLE with pc=0.
REQ-020 FETCH SHALL register instr into ir, take 1 cycle and go to EXEC.
REQ-021 In EXEC, for exactly one cycle:
- mux_sel = ir[8:7] and ram2_addr = ir[2:0].
- acc_we = ir[10], out_we = ir[9], ram2_we = ir[11].
REQ-022 mux_sel and ram2_addr SHALL hold their EXEC values through WB; all strobes SHALL be 0 in every other state.
REQ-023 In WB, pc SHALL load ir[3:0] if any of these holds, else pc+1 mod 16:
- ir[6]=1;
- ir[5]=1 and z_flag=1;
- ir[4]=1 and pz_flag=1.
REQ-024 Flags SHALL be sampled in WB, so they reflect any accumulator write made in EXEC.
REQ-025 An instruction with ir[11:4]=0 SHALL be HALT:
- EXEC drives no strobes and goes to HALT.
- In HALT, halted=1 and pc is held.
- HALT SHALL be left only by reset or by load_mode=1 (-> LOAD).
REQ-026 Each instruction SHALL take exactly 3 cycles (FETCH, EXEC, WB).
REQ-027 From WB the FSM SHALL go to FETCH if run=1, else to IDLE; deasserting run mid-instruction SHALL complete that instruction.
REQ-028 Single step:
- A step SHALL execute exactly one instruction.
- step_ack SHALL rise in WB and hold until step_req=0.
- The step re-arms only after step_req=0.
REQ-029 load_mode asserted outside IDLE/HALT SHALL be ignored until the FSM reaches IDLE.

Reset
REQ-030 While reset_count=0, the block SHALL hold:
- state IDLE; pc=0; ir=0; step armed;
- all strobes, step_ack, load_ready and halted = 0; mux_sel=00, ram2_addr=0.
This SHALL apply immediately, including mid-EXEC.
REQ-031 Leaving reset SHALL take effect on the first rising edge after reset_count=1.

Structure
REQ-032 A shared package SHALL hold:
- the state enumeration;
- the instruction bit-position constants (11 RAM2 write, 10 acc write, 9 output, 8:7 mux, 6/5/4 jumps, 3:0 target);
- the mux_sel codes.
REQ-033 Branch decision SHALL live in one combinational sub-module, lmc_branch_unit (inputs ir, z_flag, pz_flag, pc; output next_pc).

Verification
REQ-034 Load three words with load_valid held for 3 cycles -> prog_we high for 3 cycles at pc=0,1,2, then pc=3.
REQ-035 instr=0x400 at pc=0 with run=1 -> acc_we=1 only in cycle 2 after FETCH entry, mux_sel=00, pc=1 after WB.
REQ-036 instr=0x04A -> pc=0xA after WB; instr=0x025 -> pc=5 when z_flag=1, pc+1 when z_flag=0.
REQ-037 pc=15 with non-branch instr -> pc=0 after WB; instr=0x000 -> halted=1, no strobes, run ignored.
REQ-038 Step mode:
- step_req held high -> exactly one instruction executes and step_ack=1.
- step_req held longer -> no second execution.
- step_req drops -> step_ack=0.
REQ-039 reset_count driven low during EXEC of 0xE00 -> ram2_we and acc_we fall with no clock edge; state=IDLE, pc=0.
